// File: rtl/gf2m_digit_mult.sv
// gf2m_digit_mult: iterative digit-serial GF(2^M) multiplier, polynomial basis.
// Computes c = a*b mod (x^M + POLY), consuming DIGIT bits of b per clock,
// MSB first, with interleaved reduction after every bit-step.
// Valid/ready handshake on the operand side and on the result side.
module gf2m_digit_mult #(
    parameter int             M     = 163,
    parameter int             DIGIT = 4,
    parameter logic [M-1:0]   POLY  = 163'h0C9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] c,
    output logic         busy
);

    // Number of RUN cycles and the zero-padded width of the multiplier.
    localparam int N  = (M + DIGIT - 1) / DIGIT;
    localparam int NB = N * DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [M-1:0]  a_q, a_d;
    logic [NB-1:0] b_q, b_d;
    logic [M-1:0]  acc_q, acc_d;
    logic [M-1:0]  c_q, c_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          out_valid_q, out_valid_d;
    logic [M-1:0]  acc_step;

    // Multiply by x modulo f(x): shift up one place, fold x^M back as POLY.
    function automatic logic [M-1:0] xtime(input logic [M-1:0] v);
        return {v[M-2:0], 1'b0} ^ (v[M-1] ? POLY : '0);
    endfunction

    // Digit step plus next-state logic for the handshake FSM.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        c_d         = c_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;

        // Horner step over the top digit of b, highest bit first.
        acc_step = acc_q;
        for (int j = DIGIT - 1; j >= 0; j--) begin
            acc_step = xtime(acc_step) ^ (b_q[NB-DIGIT+j] ? a_q : '0);
        end

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = NB'(b);       // zero-extend: padding digits go first
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d = acc_step;
                b_d   = b_q << DIGIT;
                if (cnt_q == CW'(N - 1)) begin
                    c_d         = acc_step;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            c_q         <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            c_q         <= c_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign c         = c_q;

endmodule
